// File: rtl/debug_ctrl.sv
// Debug controller: decodes UART commands, steps/runs the MIPS core and dumps
// PC, registers, ALU result and memory over UART. Optional trailing XOR
// checksum byte is enabled by defining DEBUG_CTRL_CHECKSUM_EN.
module debug_ctrl #(
  parameter int NB               = 32,
  parameter int DATA_BITS        = 8,
  parameter int NUMBER_REGISTERS = 32,
  parameter int NUMBER_MEM_WORDS = 16,
  parameter int NB_REG           = $clog2(NUMBER_REGISTERS + 1),
  parameter int NB_STATE         = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_uart_rx_ready,
  input  logic [DATA_BITS-1:0] i_uart_rx_data,
  input  logic                 i_uart_tx_done,
  input  logic                 i_mips_halt,
  input  logic [NB-1:0]        i_mips_pc,
  input  logic [NB-1:0]        i_mips_register,
  input  logic [NB-1:0]        i_mips_mem_data,
  input  logic [NB-1:0]        i_mips_alu_result,
  output logic [NB_REG-1:0]    o_mips_register_number,
  output logic [NB-1:0]        o_mips_memory_address,
  output logic [DATA_BITS-1:0] o_uart_tx_data,
  output logic                 o_uart_tx_ready,
  output logic                 o_step,
  output logic                 o_run,
  output logic [NB_STATE-1:0]  o_state_debug
);

  localparam int BYTES_PER_WORD = NB / DATA_BITS;
  localparam int NB_BCNT        = $clog2(BYTES_PER_WORD + 1);
  localparam logic [NB_BCNT-1:0]   LAST_BYTE     = NB_BCNT'(BYTES_PER_WORD - 1);
  localparam logic [NB_REG-1:0]    LAST_REG      = NB_REG'(NUMBER_REGISTERS - 1);
  localparam logic [NB-1:0]        LAST_MEM_ADDR = NB'(4 * (NUMBER_MEM_WORDS - 1));
  localparam logic [DATA_BITS-1:0] CMD_STEP      = DATA_BITS'(8'h73);
  localparam logic [DATA_BITS-1:0] CMD_RUN       = DATA_BITS'(8'h63);
  localparam logic [DATA_BITS-1:0] CMD_DUMP      = DATA_BITS'(8'h64);

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE    = NB_STATE'(0),
    ST_STEP    = NB_STATE'(1),
    ST_RUN     = NB_STATE'(2),
    ST_FETCH   = NB_STATE'(3),
    ST_SEND    = NB_STATE'(4),
    ST_WAIT_TX = NB_STATE'(5),
    ST_CKSUM   = NB_STATE'(6)
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC  = 2'd0,
    SEC_REG = 2'd1,
    SEC_ALU = 2'd2,
    SEC_MEM = 2'd3
  } section_t;

`ifdef DEBUG_CTRL_CHECKSUM_EN
  localparam state_t ST_AFTER_DUMP = ST_CKSUM;
`else
  localparam state_t ST_AFTER_DUMP = ST_IDLE;
`endif

  state_t                 state_r, state_next;
  section_t               section_r;
  logic [NB-1:0]          shift_r;
  logic [NB_BCNT-1:0]     byte_cnt_r;
  logic [NB_REG-1:0]      reg_num_r;
  logic [NB-1:0]          mem_addr_r;
  logic                   last_word_r;
  logic [DATA_BITS-1:0]   tx_data_r;
  logic                   tx_ready_r;
  logic                   step_r;
  logic                   run_r;
  logic                   last_byte_s;
  logic                   in_cksum_s;

`ifdef DEBUG_CTRL_CHECKSUM_EN
  logic [DATA_BITS-1:0]   cksum_r;
  logic                   cksum_phase_r;
  assign in_cksum_s = cksum_phase_r;
`else
  assign in_cksum_s = 1'b0;
`endif

  assign last_byte_s            = (byte_cnt_r == LAST_BYTE);
  assign o_mips_register_number = reg_num_r;
  assign o_mips_memory_address  = mem_addr_r;
  assign o_uart_tx_data         = tx_data_r;
  assign o_uart_tx_ready        = tx_ready_r;
  assign o_step                 = step_r;
  assign o_run                  = run_r;
  assign o_state_debug          = state_r;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_r <= ST_IDLE;
    else            state_r <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!i_uart_rx_ready)                state_next = ST_IDLE;
        else if (i_uart_rx_data == CMD_STEP) state_next = ST_STEP;
        else if (i_uart_rx_data == CMD_RUN)  state_next = ST_RUN;
        else if (i_uart_rx_data == CMD_DUMP) state_next = ST_FETCH;
        else                                 state_next = ST_IDLE;
      end
      ST_STEP:  state_next = ST_FETCH;
      ST_RUN: begin
        if (i_mips_halt) state_next = ST_FETCH;
        else             state_next = ST_RUN;
      end
      ST_FETCH: state_next = ST_SEND;
      ST_SEND:  state_next = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (!i_uart_tx_done)  state_next = ST_WAIT_TX;
        else if (in_cksum_s)  state_next = ST_IDLE;
        else if (!last_byte_s) state_next = ST_SEND;
        else if (!last_word_r) state_next = ST_FETCH;
        else                  state_next = ST_AFTER_DUMP;
      end
      ST_CKSUM: begin
`ifdef DEBUG_CTRL_CHECKSUM_EN
        state_next = ST_WAIT_TX;
`else
        state_next = ST_IDLE;
`endif
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Dump datapath: word fetch, byte serialisation and UART handshake
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      section_r   <= SEC_PC;
      shift_r     <= '0;
      byte_cnt_r  <= '0;
      reg_num_r   <= '0;
      mem_addr_r  <= '0;
      last_word_r <= 1'b0;
      tx_data_r   <= '0;
      tx_ready_r  <= 1'b0;
      step_r      <= 1'b0;
      run_r       <= 1'b0;
`ifdef DEBUG_CTRL_CHECKSUM_EN
      cksum_r       <= '0;
      cksum_phase_r <= 1'b0;
`endif
    end else begin
      step_r <= (state_next == ST_STEP);
      // A halt already present at entry keeps the core clock disabled.
      run_r  <= (state_next == ST_RUN) && !i_mips_halt;
      case (state_r)
        ST_IDLE: begin
`ifdef DEBUG_CTRL_CHECKSUM_EN
          cksum_r       <= '0;
          cksum_phase_r <= 1'b0;
`endif
        end
        ST_FETCH: begin
          case (section_r)
            SEC_PC: begin
              shift_r   <= i_mips_pc;
              section_r <= SEC_REG;
            end
            SEC_REG: begin
              shift_r <= i_mips_register;
              if (reg_num_r == LAST_REG) begin
                reg_num_r <= '0;
                section_r <= SEC_ALU;
              end else begin
                reg_num_r <= reg_num_r + NB_REG'(1);
              end
            end
            SEC_ALU: begin
              shift_r   <= i_mips_alu_result;
              section_r <= SEC_MEM;
            end
            SEC_MEM: begin
              shift_r <= i_mips_mem_data;
              if (mem_addr_r == LAST_MEM_ADDR) begin
                mem_addr_r  <= '0;
                section_r   <= SEC_PC;
                last_word_r <= 1'b1;
              end else begin
                mem_addr_r <= mem_addr_r + NB'(4);
              end
            end
            default: section_r <= SEC_PC;
          endcase
        end
        ST_SEND: begin
          tx_data_r  <= shift_r[NB-1 -: DATA_BITS];
          tx_ready_r <= 1'b1;
`ifdef DEBUG_CTRL_CHECKSUM_EN
          cksum_r <= cksum_r ^ shift_r[NB-1 -: DATA_BITS];
`endif
        end
        ST_WAIT_TX: begin
          if (i_uart_tx_done) begin
            tx_ready_r <= 1'b0;
            shift_r    <= shift_r << DATA_BITS;
            if (!in_cksum_s) begin
              if (last_byte_s) begin
                byte_cnt_r  <= '0;
                last_word_r <= 1'b0;
              end else begin
                byte_cnt_r <= byte_cnt_r + NB_BCNT'(1);
              end
            end
`ifdef DEBUG_CTRL_CHECKSUM_EN
            cksum_phase_r <= !in_cksum_s && last_byte_s && last_word_r;
`endif
          end
        end
        ST_CKSUM: begin
`ifdef DEBUG_CTRL_CHECKSUM_EN
          tx_data_r  <= cksum_r;
          tx_ready_r <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ctrl.sv
// Self-checking bench for debug_ctrl: directed commands, a UART transmitter
// responder that compares every byte against a frame model built from the inputs.
module tb_debug_ctrl;
  localparam int NB  = 32;
  localparam int DB  = 8;
  localparam int NR  = 4;
  localparam int NM  = 2;
  localparam int NBR = $clog2(NR + 1);
`ifdef DEBUG_CTRL_CHECKSUM_EN
  localparam int FRAME_BYTES = 33;
`else
  localparam int FRAME_BYTES = 32;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rx_ready;
  logic [DB-1:0]  rx_data;
  logic           tx_done, resp_done, extra_done;
  logic           halt;
  logic [NB-1:0]  pc_v, alu_v, reg_d, mem_d;
  logic           mem_var;
  logic [NBR-1:0] reg_num;
  logic [NB-1:0]  mem_addr;
  logic [DB-1:0]  tx_data;
  logic           tx_ready, step, run;
  logic [3:0]     state_dbg;

  int vectors = 0;
  int errors  = 0;
  int got_n   = 0;
  int base_n  = 0;
  int step_cnt = 0;
  int run_cnt  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign tx_done = resp_done | extra_done;
  assign reg_d   = 32'(reg_num) * 32'h11;
  assign mem_d   = mem_var ? (32'hDEADBEEF ^ mem_addr) : 32'hDEADBEEF;

  debug_ctrl #(.NB(NB), .DATA_BITS(DB), .NUMBER_REGISTERS(NR), .NUMBER_MEM_WORDS(NM)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_uart_rx_ready(rx_ready), .i_uart_rx_data(rx_data),
    .i_uart_tx_done(tx_done), .i_mips_halt(halt),
    .i_mips_pc(pc_v), .i_mips_register(reg_d), .i_mips_mem_data(mem_d), .i_mips_alu_result(alu_v),
    .o_mips_register_number(reg_num), .o_mips_memory_address(mem_addr),
    .o_uart_tx_data(tx_data), .o_uart_tx_ready(tx_ready),
    .o_step(step), .o_run(run), .o_state_debug(state_dbg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame model: words in dump order, each split MSB first, optional XOR byte.
  task automatic build_frame();
    logic [31:0] w[$];
    logic [7:0]  ck;
    w.push_back(pc_v);
    for (int r = 0; r < NR; r++) w.push_back(32'(r) * 32'h11);
    w.push_back(alu_v);
    for (int m = 0; m < NM; m++) w.push_back(mem_var ? (32'hDEADBEEF ^ 32'(4 * m)) : 32'hDEADBEEF);
    exp_q.delete();
    ck = 8'h00;
    foreach (w[i]) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[i][8*b +: 8]);
        ck = ck ^ w[i][8*b +: 8];
      end
    end
`ifdef DEBUG_CTRL_CHECKSUM_EN
    exp_q.push_back(ck);
`endif
    base_n = got_n;
  endtask

  // UART transmitter model and byte comparator
  initial begin : tx_responder
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_ready) begin
        if (got_n - base_n < exp_q.size())
          chk($sformatf("byte%0d", got_n - base_n), 64'(tx_data), 64'(exp_q[got_n - base_n]));
        else
          chk("extra_byte", 64'(got_n - base_n + 1), 64'(exp_q.size()));
        got_n++;
        repeat (2) @(negedge clk);
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  initial begin : pulse_monitor
    forever begin
      @(negedge clk);
      if (step) step_cnt++;
      if (run)  run_cnt++;
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ((got_n - base_n) >= exp_q.size() && state_dbg == 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_done"}, 64'(ok), 64'd1);
    repeat (5) @(negedge clk);
    chk({name, "_len"}, 64'(got_n - base_n), 64'(exp_q.size()));
    chk({name, "_idle"}, 64'(state_dbg), 64'd0);
  endtask

  function automatic logic [63:0] outs();
    return 64'({tx_data, tx_ready, step, run, state_dbg, reg_num, mem_addr});
  endfunction

  initial begin : main
    int s0, r0;
    bit ok;
    rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; extra_done = 1'b0;
    halt = 1'b0; pc_v = 32'h00000010; alu_v = 32'hA5A5A5A5; mem_var = 1'b0;
    #1;
    chk("reset_outputs", outs(), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Step test, with literal pins on the frame model
    build_frame();
    chk("model_size", 64'(exp_q.size()), 64'(FRAME_BYTES));
    chk("model_pc", 64'(exp_q[3]), 64'h10);
    chk("model_r3", 64'(exp_q[19]), 64'h33);
    chk("model_alu", 64'(exp_q[20]), 64'hA5);
    chk("model_mem", 64'({exp_q[28], exp_q[31]}), 64'hDEEF);
`ifdef DEBUG_CTRL_CHECKSUM_EN
    chk("model_cksum", 64'(exp_q[32]), 64'h10);
`endif
    s0 = step_cnt; r0 = run_cnt;
    send_cmd(8'h73);
    wait_frame("step");
    chk("step_pulses", 64'(step_cnt - s0), 64'd1);
    chk("step_run", 64'(run_cnt - r0), 64'd0);

    // Run test: halt raised after 7 cycles of o_run
    build_frame();
    s0 = step_cnt; r0 = run_cnt;
    send_cmd(8'h63);
    repeat (6) @(posedge clk);
    #1 halt = 1'b1;
    wait_frame("run");
    chk("run_cycles", 64'(run_cnt - r0), 64'd7);
    chk("run_step", 64'(step_cnt - s0), 64'd0);

    // Run with halt already set: no o_run at all
    build_frame();
    r0 = run_cnt;
    send_cmd(8'h63);
    wait_frame("run_halted");
    chk("run_halted_cycles", 64'(run_cnt - r0), 64'd0);
    halt = 1'b0;

    // Unknown command, then dump-only with address-dependent memory
    build_frame();
    exp_q.delete();
    s0 = step_cnt; r0 = run_cnt;
    send_cmd(8'h78);
    repeat (20) @(negedge clk);
    chk("x_bytes", 64'(got_n - base_n), 64'd0);
    chk("x_state", 64'(state_dbg), 64'd0);
    mem_var = 1'b1; pc_v = 32'h12345678; alu_v = 32'h0F0F00F0;
    build_frame();
    send_cmd(8'h64);
    wait_frame("dump");
    chk("dump_step", 64'(step_cnt - s0), 64'd0);
    chk("dump_run", 64'(run_cnt - r0), 64'd0);
    mem_var = 1'b0; pc_v = 32'h00000010; alu_v = 32'hA5A5A5A5;

    // Robustness: command during WAIT_TX and tx_done while idle
    build_frame();
    s0 = step_cnt;
    send_cmd(8'h73);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (state_dbg == 4'd5) begin ok = 1'b1; break; end
    end
    chk("reach_wait_tx", 64'(ok), 64'd1);
    send_cmd(8'h73);
    wait_frame("robust");
    @(negedge clk) extra_done = 1'b1;
    @(negedge clk) extra_done = 1'b0;
    repeat (20) @(negedge clk);
    chk("robust_len", 64'(got_n - base_n), 64'(exp_q.size()));
    chk("robust_steps", 64'(step_cnt - s0), 64'd1);
    chk("robust_idle", 64'({state_dbg, tx_ready}), 64'd0);

    // Reset after the 10th byte
    build_frame();
    send_cmd(8'h73);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (got_n - base_n >= 10) begin ok = 1'b1; break; end
    end
    chk("reach_byte10", 64'(ok), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("after_reset_len", 64'(got_n - base_n), 64'd10);
    chk("after_reset_state", 64'({state_dbg, tx_ready}), 64'd0);

    // Fresh frame after reset must start from the PC again
    build_frame();
    send_cmd(8'h73);
    wait_frame("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
